blocked_mul_engine: RTL and testbench
=====================================

# blocked_mul_engine

Multi-cycle schoolbook multiplier that splits two `DATA_LENGTH`-bit unsigned operands into `BLOCK_LENGTH`-bit limbs. It issues one limb×limb multiply per cycle into a double-width accumulator. This is the parametrised successor of the fixed 64/16 multiplier: width and limb size are generic, and it adds a start/ready/done handshake and a low-half mode that skips partial products above bit `DATA_LENGTH-1`. It sits between operand-producing logic and any consumer needing full or truncated products.

## Interface
- `DATA_LENGTH`, 64, operand width; must be an integer multiple of `BLOCK_LENGTH`.
- `BLOCK_LENGTH`, 16, limb width; `NUM_BLOCKS = DATA_LENGTH/BLOCK_LENGTH` ≥ 1.
- `LENGTH`, 16, counter width; must satisfy 2^LENGTH > NUM_BLOCKS².
- `clk_i`  in  1  clock. The block uses one clock and is fully synchronous.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `start_i`  in  1  request; sampled only while `ready_o`=1.
- `mode_i`  in  1  0 = full product, 1 = low half only (product mod 2^DATA_LENGTH); latched with operands.
- `a_i`, `b_i`  in  DATA_LENGTH  unsigned operands; latched on accepted start.
- `ready_o`  out  1  high in idle; start accepted when `start_i`&`ready_o`.
- `busy_o`  out  1  high in compute and finish.
- `done_o`  out  1  one-cycle pulse, result valid.
- `result_o`  out  2*DATA_LENGTH  registered product; held until the next completion.

## Operation
- States: `idle` → `compute` → `finish` → `idle`.
- **idle**
  - `ready_o`=1.
  - On `start_i`=1: latch `a_i`, `b_i` and `mode_i`, clear the accumulator, set limb indices i=0, j=0, and go to compute.
- **compute**
  - Each cycle, add `a_limb[i]*b_limb[j]` (2*BLOCK_LENGTH bits), shifted left by (i+j)*BLOCK_LENGTH, into the 2*DATA_LENGTH-bit accumulator. Wrap is modulo 2^(2*DATA_LENGTH) and cannot occur for the full product.
  - Iteration order: i is the inner index and j the outer index.
  - Full mode: i runs 0..NUM_BLOCKS-1 for each j. That gives N = NUM_BLOCKS² steps (16 at default).
  - Low mode: i runs 0..NUM_BLOCKS-1-j, so pairs with i+j ≥ NUM_BLOCKS are skipped. That gives N = NUM_BLOCKS(NUM_BLOCKS+1)/2 steps (10 at default).
  - The step counter (LENGTH bits) counts issued multiplies. The last step moves the FSM to finish.
- **finish**
  - `result_o` ← accumulator. In low mode, bits [2*DATA_LENGTH-1:DATA_LENGTH] are forced to 0.
  - `done_o`=1 for this single cycle, then go to idle.
- `start_i` while busy is ignored: operands, mode and the operation in progress are unaffected.
- Reset (`rst_ni`=0 at a clock edge, at any time including mid-compute):
  - state=idle, accumulator, counter and indices = 0.
  - Outputs: `ready_o`=1, `busy_o`=0, `done_o`=0, `result_o`=0.
  - The aborted operation produces no `done_o`.

## Timing
- Start sampled high in cycle 0 → compute in cycles 1..N → `done_o`=1 and `result_o` valid in cycle N+1 → `ready_o`=1 in cycle N+2.
- Default latency from start to done: full mode 17 cycles, low mode 11 cycles.
- Minimum start-to-start spacing is N+2 cycles. Holding `start_i` high launches the next operation in cycle N+2.
- `ready_o`, `busy_o` and `done_o` decode directly from the registered state. `result_o` changes only on the finish edge or on reset.
- NUM_BLOCKS=1: N=1 in both modes. Done arrives in cycle 2.

## Test plan
- Full mode, a=b=0xFFFF_FFFF_FFFF_FFFF → `result_o`=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, `done_o` high in cycle 17 only, `ready_o` high in cycle 18.
- Low mode, same operands → `result_o`=0x0000_0000_0000_0000_0000_0000_0000_0001, done in cycle 11.
- Full mode, a=2^32, b=2^40 → `result_o`=2^72 (upper word 0x100, lower word 0). The same operands in low mode → `result_o`=0.
- Start a=3, b=5 (full). Pulse `start_i` with a=7, b=7 in cycles 4 and 16 → result 15 in cycle 17. The second request is ignored.
- Start a full operation, drive `rst_ni`=0 in cycle 5 → next cycle all outputs are at reset values and no `done_o` appears. Then start a=0x1234, b=0x10 → result 0x12340 in cycle 17 after that start.
- Hold `start_i`=1 for two operations: (a=2, b=3) then (a=4, b=5) → results 6 and 20, with `done_o` pulses exactly 18 cycles apart.

Source files
------------

// File: rtl/blocked_mul_engine.sv
// Schoolbook limb-by-limb multiplier: one BLOCK_LENGTH x BLOCK_LENGTH product per cycle
// into a double-width accumulator, with optional low-half (mod 2^DATA_LENGTH) mode.
//
// state     | meaning
// S_IDLE    | ready for a start request
// S_COMPUTE | issuing one limb product per cycle
// S_FINISH  | result valid, done pulse
module blocked_mul_engine #(
  parameter int DATA_LENGTH  = 64,
  parameter int BLOCK_LENGTH = 16,
  parameter int LENGTH       = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       mode_i,
  input  logic [DATA_LENGTH-1:0]     a_i,
  input  logic [DATA_LENGTH-1:0]     b_i,
  output logic                       ready_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [2*DATA_LENGTH-1:0]   result_o
);

  localparam int NUM_BLOCKS = DATA_LENGTH / BLOCK_LENGTH;
  localparam int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [LENGTH-1:0] N_FULL = LENGTH'(NUM_BLOCKS * NUM_BLOCKS);
  localparam logic [LENGTH-1:0] N_LOW  = LENGTH'(NUM_BLOCKS * (NUM_BLOCKS + 1) / 2);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FINISH} state_t;

  state_t                                     state;
  logic [NUM_BLOCKS-1:0][BLOCK_LENGTH-1:0]    a_q;
  logic [NUM_BLOCKS-1:0][BLOCK_LENGTH-1:0]    b_q;
  logic                                       mode_q;
  logic [2*DATA_LENGTH-1:0]                   acc;
  logic [LENGTH-1:0]                          cnt;
  logic [IDX_W-1:0]                           i_idx;
  logic [IDX_W-1:0]                           j_idx;

  logic [2*BLOCK_LENGTH-1:0]                  prod;
  logic [2*DATA_LENGTH-1:0]                   term;
  logic [2*DATA_LENGTH-1:0]                   acc_next;
  logic                                       last_i;
  logic                                       last_step;

  always_comb begin
    prod = {{BLOCK_LENGTH{1'b0}}, a_q[i_idx]} * {{BLOCK_LENGTH{1'b0}}, b_q[j_idx]};
    term = '0;
    term[2*BLOCK_LENGTH-1:0] = prod;
    term = term << ((int'(i_idx) + int'(j_idx)) * BLOCK_LENGTH);
    acc_next = acc + term;
    // Low mode shortens each inner pass so i+j never reaches NUM_BLOCKS.
    if (mode_q)
      last_i = (int'(i_idx) == NUM_BLOCKS - 1 - int'(j_idx));
    else
      last_i = (int'(i_idx) == NUM_BLOCKS - 1);
    last_step = (cnt == ((mode_q ? N_LOW : N_FULL) - LENGTH'(1)));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      i_idx    <= '0;
      j_idx    <= '0;
      result_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            mode_q <= mode_i;
            acc    <= '0;
            cnt    <= '0;
            i_idx  <= '0;
            j_idx  <= '0;
            state  <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          acc <= acc_next;
          cnt <= cnt + LENGTH'(1);
          if (last_i) begin
            i_idx <= '0;
            j_idx <= j_idx + IDX_W'(1);
          end else begin
            i_idx <= i_idx + IDX_W'(1);
          end
          // Result is loaded on the edge into finish so it is valid alongside done.
          if (last_step) begin
            if (mode_q)
              result_o <= {{DATA_LENGTH{1'b0}}, acc_next[DATA_LENGTH-1:0]};
            else
              result_o <= acc_next;
            state <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign ready_o = (state == S_IDLE);
  assign busy_o  = (state == S_COMPUTE) || (state == S_FINISH);
  assign done_o  = (state == S_FINISH);

endmodule

// File: tb/tb_blocked_mul_engine.sv
// Self-checking bench for blocked_mul_engine: directed cases plus random operands
// compared against a plain-arithmetic product model.
module tb_blocked_mul_engine;
  localparam int DL = 64;
  localparam int BL = 16;
  localparam int NB = DL / BL;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic          mode_i;
  logic [DL-1:0] a_i;
  logic [DL-1:0] b_i;
  logic          ready_o;
  logic          busy_o;
  logic          done_o;
  logic [2*DL-1:0] result_o;

  int passed = 0;
  int total  = 0;

  blocked_mul_engine #(.DATA_LENGTH(DL), .BLOCK_LENGTH(BL), .LENGTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .a_i(a_i), .b_i(b_i), .ready_o(ready_o), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic m);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    if (m) p = p % (128'd1 << DL);
    return p;
  endfunction

  function automatic int ref_lat(input logic m);
    return (m ? NB * (NB + 1) / 2 : NB * NB) + 1;
  endfunction

  // Start in the current cycle (cycle 0), scramble inputs afterwards, wait for done.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic m);
    int lat;
    @(negedge clk_i);
    a_i = a; b_i = b; mode_i = m; start_i = 1'b1;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      a_i = {$urandom, $urandom};
      b_i = {$urandom, $urandom};
      mode_i = ~m;
      if (c == 1) check({tag, " busy"}, busy_o, 1'b1);
      if (done_o) begin lat = c; break; end
    end
    check({tag, " latency"}, lat, ref_lat(m));
    check({tag, " result"}, result_o, ref_mul(a, b, m));
    @(negedge clk_i);
    check({tag, " done_one_cycle"}, done_o, 1'b0);
    check({tag, " ready_after"}, ready_o, 1'b1);
  endtask

  initial begin
    int lat;
    int d1;
    int d2;
    bit saw_done;
    logic [63:0] ra;
    logic [63:0] rb;
    logic rm;

    rst_ni = 1'b0; start_i = 1'b0; mode_i = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst ready", ready_o, 1'b1);
    check("rst busy", busy_o, 1'b0);
    check("rst done", done_o, 1'b0);
    check("rst result", result_o, 128'd0);
    rst_ni = 1'b1;

    run_op("full_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("full_ones const", result_o, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    run_op("low_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("low_ones const", result_o, 128'd1);
    run_op("pow_full", 64'd1 << 32, 64'd1 << 40, 1'b0);
    check("pow_full const", result_o, 128'd1 << 72);
    run_op("pow_low", 64'd1 << 32, 64'd1 << 40, 1'b1);
    check("pow_low const", result_o, 128'd0);

    // Starts during compute must be ignored.
    @(negedge clk_i);
    a_i = 64'd3; b_i = 64'd5; mode_i = 1'b0; start_i = 1'b1;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk_i);
      start_i = (c == 4 || c == 16);
      a_i = 64'd7; b_i = 64'd7;
      if (done_o) begin lat = c; break; end
    end
    start_i = 1'b0;
    check("ignore latency", lat, 17);
    check("ignore result", result_o, 128'd15);

    // Reset in the middle of an operation.
    @(negedge clk_i);
    a_i = 64'hDEAD; b_i = 64'hBEEF; mode_i = 1'b0; start_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("abort ready", ready_o, 1'b1);
    check("abort busy", busy_o, 1'b0);
    check("abort done", done_o, 1'b0);
    check("abort result", result_o, 128'd0);
    rst_ni = 1'b1;
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk_i);
      if (done_o) saw_done = 1'b1;
    end
    check("abort no_done", saw_done, 1'b0);
    run_op("after_abort", 64'h1234, 64'h10, 1'b0);
    check("after_abort const", result_o, 128'h12340);

    // Back-to-back with start held high.
    @(negedge clk_i);
    a_i = 64'd2; b_i = 64'd3; mode_i = 1'b0; start_i = 1'b1;
    d1 = -1; d2 = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk_i);
      if (done_o) begin
        if (d1 < 0) begin
          d1 = c;
          check("b2b first result", result_o, 128'd6);
          a_i = 64'd4; b_i = 64'd5;
        end else begin
          d2 = c;
          check("b2b second result", result_o, 128'd20);
          start_i = 1'b0;
          break;
        end
      end
    end
    start_i = 1'b0;
    check("b2b first latency", d1, 17);
    check("b2b spacing", d2 - d1, 18);
    repeat (3) @(negedge clk_i);

    for (int k = 0; k < 20; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (k % 5 == 0) ra = ra >> $urandom_range(0, 63);
      rm = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", k), ra, rb, rm);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
